// File: rtl/spi_amp_adc_responder_pkg.sv
// Shared types and default sizes for the amp/ADC SPI responder.
package spi_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    AMP_RX = 2'd1,
    ADC_TX = 2'd2,
    DONE   = 2'd3
  } spi_state_e;

  localparam int SPI_DATA_W    = 8;
  localparam int SPI_LEAD_BITS = 2;
  localparam int SPI_GAIN_W    = 8;

  // Amp frame length; the controller's reference load word is 8'h11.
  localparam int         SPI_AMP_FRAME_LEN = 8;
  localparam logic [7:0] SPI_REF_GAIN      = 8'h11;

endpackage

// File: rtl/spi_amp_adc_responder_if.sv
// SPI pin bundle between controller (master) and responder (slave).
interface spi_amp_adc_responder_if;
  logic spi_clk;
  logic mosi;
  logic amp_cs_n;
  logic adc_conv;
  logic miso;

  modport master (output spi_clk, output mosi, output amp_cs_n, output adc_conv, input miso);
  modport slave  (input spi_clk, input mosi, input amp_cs_n, input adc_conv, output miso);
endinterface

// File: rtl/spi_amp_adc_responder_sync_edge.sv
// Two-flop synchronizer followed by an edge register; rise/fall pulses last one clk.
module sync_edge #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic rise,
  output logic fall
);

  logic [2:0] sr;

  always_ff @(posedge clk) begin
    if (rst) begin
      sr <= {3{RST_VAL}};
    end else begin
      sr <= {sr[1:0], din};
    end
  end

  // sr[2] is the edge register; pulses are valid the cycle after the second sync flop.
  assign rise = sr[1] & ~sr[2];
  assign fall = ~sr[1] & sr[2];

endmodule

// File: rtl/spi_amp_adc_responder.sv
// SPI target: captures the amp gain word on MOSI and returns a latched ADC sample on MISO.
module spi_amp_adc_responder
  import spi_pkg::*;
#(
  parameter int DATA_W    = SPI_DATA_W,
  parameter int LEAD_BITS = SPI_LEAD_BITS,
  parameter int GAIN_W    = SPI_GAIN_W
) (
  input  logic                  clk,
  input  logic                  rst,
  spi_amp_adc_responder_if.slave spi,
  input  logic [DATA_W-1:0]     sample_in,
  output logic [GAIN_W-1:0]     gain,
  output logic                  gain_valid,
  output logic                  frame_err,
  output logic                  sample_done,
  output logic                  busy
);

  localparam int TX_W  = LEAD_BITS + DATA_W;
  localparam int CNT_W = $clog2(TX_W + 1);
  localparam logic [CNT_W-1:0] RX_FULL = CNT_W'(GAIN_W);
  localparam logic [CNT_W-1:0] RX_SAT  = CNT_W'(GAIN_W + 1);
  localparam logic [CNT_W-1:0] TX_LAST = CNT_W'(TX_W - 1);

  logic sck_rise, sck_fall;
  logic cs_rise, cs_fall;
  logic conv_rise, conv_fall_unused;

  sync_edge #(.RST_VAL(1'b0)) u_sync_sck (
    .clk (clk), .rst (rst), .din (spi.spi_clk), .rise (sck_rise), .fall (sck_fall)
  );

  sync_edge #(.RST_VAL(1'b1)) u_sync_cs (
    .clk (clk), .rst (rst), .din (spi.amp_cs_n), .rise (cs_rise), .fall (cs_fall)
  );

  sync_edge #(.RST_VAL(1'b0)) u_sync_conv (
    .clk (clk), .rst (rst), .din (spi.adc_conv), .rise (conv_rise), .fall (conv_fall_unused)
  );

  spi_state_e        state;
  logic [CNT_W-1:0]  cnt;
  logic [GAIN_W-1:0] shift_rx;
  logic [TX_W-1:0]   shift_tx;
  logic [1:0]        mosi_sync;
  logic              miso_q;

  assign spi.miso = miso_q;

  // mosi goes through the same two-flop depth as spi_clk so the sampled bit lines up with sck_rise.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      busy        <= 1'b0;
      cnt         <= '0;
      shift_rx    <= '0;
      shift_tx    <= '0;
      mosi_sync   <= '0;
      miso_q      <= 1'b0;
      gain        <= '0;
      gain_valid  <= 1'b0;
      frame_err   <= 1'b0;
      sample_done <= 1'b0;
    end else begin
      mosi_sync   <= {mosi_sync[0], spi.mosi};
      gain_valid  <= 1'b0;
      frame_err   <= 1'b0;
      sample_done <= 1'b0;

      unique case (state)
        IDLE: begin
          if (cs_fall) begin
            state    <= AMP_RX;
            busy     <= 1'b1;
            cnt      <= '0;
            shift_rx <= '0;
          end else if (conv_rise) begin
            state    <= ADC_TX;
            busy     <= 1'b1;
            cnt      <= '0;
            shift_tx <= {{LEAD_BITS{1'b0}}, sample_in};
            miso_q   <= 1'b0;
          end
        end

        AMP_RX: begin
          if (cs_rise) begin
            state <= IDLE;
            busy  <= 1'b0;
            if (cnt == RX_FULL) begin
              gain       <= shift_rx;
              gain_valid <= 1'b1;
            end else begin
              frame_err <= 1'b1;
            end
          end else if (sck_rise) begin
            shift_rx <= {shift_rx[GAIN_W-2:0], mosi_sync[1]};
            if (cnt != RX_SAT) cnt <= cnt + 1'b1;
          end
        end

        ADC_TX: begin
          if (sck_fall) begin
            // The fall after the last data bit ends the frame and returns miso to idle low.
            if (cnt == TX_LAST) begin
              miso_q <= 1'b0;
              state  <= DONE;
            end else begin
              shift_tx <= shift_tx << 1;
              miso_q   <= shift_tx[TX_W-2];
              cnt      <= cnt + 1'b1;
            end
          end
        end

        DONE: begin
          sample_done <= 1'b1;
          state       <= IDLE;
          busy        <= 1'b0;
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/spi_amp_adc_responder.md
# spi_amp_adc_responder

SPI target that models the preamp/ADC end of the amplifier–converter SPI link. It receives the 8-bit gain word that the controller shifts out on MOSI while the amp chip-select is low. On each conversion strobe it shifts a captured sample back on MISO, framed exactly as the controller expects. It sits on the peripheral side of the link and serves as the loopback partner for controller bring-up and board-less regression.

## Interface
- DATA_W, 8: sample width returned on MISO.
- LEAD_BITS, 2: zero bits driven before the sample MSB.
- GAIN_W, 8: gain word width received on MOSI.
- clk  in  1  system clock; all logic on its rising edge.
- rst  in  1  reset, synchronous, active-high.
- spi_clk  in  1  SPI clock from controller, asynchronous to clk.
- mosi  in  1  serial data from controller, MSB first.
- amp_cs_n  in  1  amp select, active-low, asynchronous.
- adc_conv  in  1  conversion strobe, asynchronous; rising edge starts an ADC frame.
- sample_in  in  DATA_W  parallel sample, latched at conversion.
- miso  out  1  serial sample to controller.
- gain  out  GAIN_W  last valid gain word.
- gain_valid  out  1  one-clk pulse when gain updates.
- frame_err  out  1  one-clk pulse on a malformed amp frame.
- sample_done  out  1  one-clk pulse at the end of an ADC frame.
- busy  out  1  high whenever state is not IDLE.

## Operation
- spi_clk, amp_cs_n and adc_conv each pass through a 2-flop synchronizer plus an edge detector. All internal decisions use the resulting rise/fall pulses; raw pins never feed logic.
- The responder has four states: IDLE, AMP_RX, ADC_TX, DONE.
- IDLE:
  - amp_cs_n fall → AMP_RX, bit counter cleared.
  - Otherwise adc_conv rise → ADC_TX.
  - If both are detected in the same cycle, amp_cs_n wins.
- AMP_RX:
  - Each spi_clk rise shifts mosi into shift_rx (left shift, MSB first). The bit counter saturates at GAIN_W+1.
  - amp_cs_n rise with count == GAIN_W: gain ← shift_rx, gain_valid pulse, → IDLE.
  - amp_cs_n rise with any other count: frame_err pulse, gain unchanged, → IDLE.
  - adc_conv edges are ignored in this state.
- ADC_TX:
  - On entry: shift_tx ← {LEAD_BITS zeros, sample_in}, miso ← shift_tx MSB (0), edge counter cleared.
  - Each spi_clk fall shifts shift_tx left, drives the new MSB onto miso, and increments the counter.
  - When the counter reaches LEAD_BITS+DATA_W−1 falls, the last data bit is on miso. The next fall forces miso to 0 and moves to DONE.
  - amp_cs_n and adc_conv edges are ignored in this state.
- DONE: sample_done pulse, → IDLE (one cycle).
- Reset:
  - Values: miso=0, gain=0, gain_valid=0, frame_err=0, sample_done=0, busy=0, state=IDLE, all counters and shift registers 0.
  - A reset mid-frame abandons the frame silently, with no pulse.
- Counters are sized to $clog2(LEAD_BITS+DATA_W+1) and never wrap.

## Timing
- Pin-edge to internal pulse latency: 3 clk (2 sync + 1 edge register).
- miso changes 3 clk after a spi_clk pin fall. The controller samples on spi_clk rise.
- Required: spi_clk high and low phases each ≥ 4 clk (the controller's divide-by-8 gives exactly 4).
- gain_valid, frame_err and sample_done are single-cycle and mutually exclusive.
- gain changes only in the same cycle as gain_valid.
- adc_conv pulse width must be ≥ 2 clk. The first spi_clk fall must come ≥ 4 clk after the adc_conv pin rise.

## Structure
- Package spi_pkg holds:
  - the state enum (IDLE, AMP_RX, ADC_TX, DONE);
  - default constants SPI_DATA_W=8, SPI_LEAD_BITS=2, SPI_GAIN_W=8;
  - the amp frame length 8 (controller load word 8'h11 is the reference gain).
- One sub-module, sync_edge: 2-flop synchronizer plus rise/fall pulse outputs, reset to 0 (idle-high inputs such as amp_cs_n reset to 1 via a RST_VAL parameter). It is instantiated three times.
- Everything else is one FSM module.

## Test plan
- Reset held 5 clk with random pin activity → every output 0, busy=0. amp_cs_n held high produces no spurious fall after reset release.
- Amp frame: amp_cs_n low, 8 spi_clk cycles (half-period 4 clk) carrying 8'h11, amp_cs_n high → gain=8'h11 and one gain_valid pulse 3–4 clk after the cs_n pin rise.
- Short amp frame: 6 bits, then cs_n high → one frame_err pulse, gain keeps its previous 8'h11, no gain_valid.
- ADC frame:
  - Stimulus: sample_in=8'hA5, adc_conv pulse, 10 spi_clk cycles, controller samples on rises.
  - Required: bits 0,0,1,0,1,0,0,1,0,1; miso=0 afterwards; one sample_done pulse; busy low after DONE.
- rst asserted after the 4th spi_clk fall of an ADC frame → miso=0, state IDLE, no sample_done. A following frame with sample_in=8'h3C returns 0,0,0,0,1,1,1,1,0,0.
- amp_cs_n fall and adc_conv rise synchronized in the same cycle → AMP_RX taken, the adc_conv edge is dropped, the 8-bit gain is captured, and miso stays 0 throughout.
